// File: rtl/ham8b_pkg.sv
// Purpose : shared constants, FSM state type and Hamming 12/8 encode function.
// Latency : n/a (package only).
// Backpressure: n/a.
//
// Codeword positions 1..12 map to code[11..0]:
//   P1 P2 D1 P3 D2 D3 D4 P4 D5 D6 D7 D8, even parity, D1 = data[7].
package ham8b_pkg;

    localparam int HAM8B_CODE_W = 12;
    localparam int HAM8B_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } ham8b_state_t;

    function automatic logic [HAM8B_CODE_W-1:0] ham8b_encode(input logic [HAM8B_DATA_W-1:0] data);
        logic d1, d2, d3, d4, d5, d6, d7, d8;
        logic p1, p2, p3, p4;
        d1 = data[7];
        d2 = data[6];
        d3 = data[5];
        d4 = data[4];
        d5 = data[3];
        d6 = data[2];
        d7 = data[1];
        d8 = data[0];
        p1 = d1 ^ d2 ^ d4 ^ d5 ^ d7;
        p2 = d1 ^ d3 ^ d4 ^ d6 ^ d7;
        p3 = d2 ^ d3 ^ d4 ^ d8;
        p4 = d5 ^ d6 ^ d7 ^ d8;
        return {p1, p2, d1, p3, d2, d3, d4, p4, d5, d6, d7, d8};
    endfunction

endpackage

// File: rtl/ham8b_encoder.sv
// Purpose : combinational 8-bit to 12-bit even-parity Hamming encoder.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; output follows input.
//
// Ports:
//   i_data  [7:0]  payload byte, i_data[7] = D1
//   o_code  [11:0] codeword, o_code[11] = position 1
module ham8b_encoder
    import ham8b_pkg::*;
(
    input  logic [HAM8B_DATA_W-1:0] i_data,
    output logic [HAM8B_CODE_W-1:0] o_code
);

    assign o_code = ham8b_encode(i_data);

endmodule

// File: rtl/ham8b_ser_tx.sv
// Purpose : accept a byte, encode to a Hamming 12/8 codeword, register it and send it
//           as a start bit, 12 code bits MSB first and a stop bit on a UART-like line.
// Latency : codeword, code_valid pulse and start bit appear the cycle after the transfer;
//           a frame lasts 14*BIT_DIV cycles.
// Backpressure: data_ready is high only in IDLE; data_valid is ignored while a frame is sent.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   data_in/valid/ready     byte input handshake
//   code_out, code_valid    last codeword, one-cycle update pulse
//   tx_out, tx_busy         serial line (idle high), frame-in-progress flag
//   err_inj, err_pos        single-bit error injection, only with HAM8B_ERR_INJ_EN defined
module ham8b_ser_tx
    import ham8b_pkg::*;
#(
    parameter int BIT_DIV = 4
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [HAM8B_DATA_W-1:0] data_in,
    input  logic                    data_valid,
    output logic                    data_ready,
    output logic [HAM8B_CODE_W-1:0] code_out,
    output logic                    code_valid,
    output logic                    tx_out,
`ifdef HAM8B_ERR_INJ_EN
    output logic                    tx_busy,
    input  logic                    err_inj,
    input  logic [3:0]              err_pos
`else
    output logic                    tx_busy
`endif
);

    localparam int                DIV_W    = $clog2(BIT_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    ham8b_state_t            r_state;
    logic                    r_ready;
    logic [HAM8B_CODE_W-1:0] r_code;
    logic                    r_code_vld;
    logic                    r_tx;
    logic                    r_busy;
    logic [DIV_W-1:0]        r_div;
    logic [3:0]              r_bit_idx;

    logic [HAM8B_CODE_W-1:0] w_enc;
    logic [HAM8B_CODE_W-1:0] w_err_mask;
    logic [HAM8B_CODE_W-1:0] w_code;
    logic                    w_div_done;

    ham8b_encoder u_enc (
        .i_data (data_in),
        .o_code (w_enc)
    );

`ifdef HAM8B_ERR_INJ_EN
    // Position p lives at code bit 12-p; positions outside 1..12 leave the word clean.
    assign w_err_mask = (err_inj && (err_pos >= 4'd1) && (err_pos <= 4'd12))
                      ? (12'b1 << (4'd12 - err_pos)) : '0;
`else
    assign w_err_mask = '0;
`endif

    assign w_code     = w_enc ^ w_err_mask;
    assign w_div_done = (r_div == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ready    <= 1'b1;
            r_code     <= '0;
            r_code_vld <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_div      <= '0;
            r_bit_idx  <= '0;
        end else begin
            r_code_vld <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (data_valid && r_ready) begin
                        r_code     <= w_code;
                        r_code_vld <= 1'b1;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_ready    <= 1'b0;
                        r_div      <= '0;
                        r_state    <= START;
                    end
                end
                START: begin
                    if (w_div_done) begin
                        r_div     <= '0;
                        r_bit_idx <= 4'd11;
                        r_tx      <= r_code[11];
                        r_state   <= DATA;
                    end else begin
                        r_div <= r_div + DIV_ONE;
                    end
                end
                DATA: begin
                    // r_code is stable for the whole frame, so it is serialized in place.
                    if (w_div_done) begin
                        r_div <= '0;
                        if (r_bit_idx == 4'd0) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx - 4'd1;
                            r_tx      <= r_code[r_bit_idx - 4'd1];
                        end
                    end else begin
                        r_div <= r_div + DIV_ONE;
                    end
                end
                STOP: begin
                    if (w_div_done) begin
                        r_div   <= '0;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_div <= r_div + DIV_ONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_ready = r_ready;
    assign code_out   = r_code;
    assign code_valid = r_code_vld;
    assign tx_out     = r_tx;
    assign tx_busy    = r_busy;

endmodule
